// File: rtl/dds_pkg.sv
// dds_pkg: shared wave codes and config register addresses for the multi-channel DDS
package dds_pkg;
  localparam logic [1:0] WAVE_SIN = 2'd0;
  localparam logic [1:0] WAVE_SQU = 2'd1;
  localparam logic [1:0] WAVE_TRI = 2'd2;
  localparam logic [1:0] WAVE_SAW = 2'd3;
  localparam logic [1:0] ADDR_FREQ = 2'd0;
  localparam logic [1:0] ADDR_PHASE = 2'd1;
  localparam logic [1:0] ADDR_WAVE = 2'd2;
endpackage

// File: rtl/dds_sin_lut.sv
// dds_sin_lut: registered sine lookup built from a quarter-wave table with symmetry folding
module dds_sin_lut #(
  parameter int PHASE_W = 12,
  parameter int OUT_W = 8
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic [PHASE_W-1:0] phase,
  output logic [OUT_W-1:0] sample
);
  localparam int QW = PHASE_W - 2;
  localparam int N = 2 ** QW;
  localparam real PI = 3.141592653589793;
  localparam real AMP = (2.0 ** (OUT_W - 1)) - 1.0;
  localparam logic [OUT_W-1:0] MID = OUT_W'(1) << (OUT_W - 1);
  function automatic logic [OUT_W-2:0] qsin(input int k);
    return (OUT_W-1)'($rtoi(AMP * $sin(2.0 * PI * k / (2.0 ** PHASE_W)) + 0.5));
  endfunction
  logic [OUT_W-2:0] rom [N];
  logic [QW-1:0] idx;
  logic [OUT_W-2:0] mag;
  for (genvar k = 0; k < N; k++) begin : g_rom
    assign rom[k] = qsin(k);
  end
  // odd quadrants read the table backwards; the exact quarter point is the peak, which the table never holds
  assign idx = phase[PHASE_W-2] ? -phase[QW-1:0] : phase[QW-1:0];
  assign mag = phase[PHASE_W-2] && phase[QW-1:0] == '0 ? '1 : rom[idx];
  // second half of the period is the negated magnitude around mid-scale
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) sample <= '0;
    else sample <= phase[PHASE_W-1] ? MID - mag : MID + mag;
endmodule

// File: rtl/dds_multi.sv
// dds_multi: multi-channel DDS with shadowed config and a single coherent update strobe
module dds_multi
  import dds_pkg::*;
#(
  parameter int CH = 2,
  parameter int ACC_W = 32,
  parameter int PHASE_W = 12,
  parameter int OUT_W = 8
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic cfg_valid,
  output logic cfg_ready,
  input  logic [$clog2(CH > 1 ? CH : 2)-1:0] cfg_ch,
  input  logic [1:0] cfg_addr,
  input  logic [ACC_W-1:0] cfg_data,
  input  logic update,
  input  logic phase_clr,
  output logic [CH*OUT_W-1:0] data_out,
  output logic data_valid
);
  localparam int CW = $clog2(CH > 1 ? CH : 2);
  logic take;
  logic [3:0] vld;
  assign take = cfg_valid && cfg_ready;
  assign data_valid = vld[3];
  // ready drops for the commit cycle only; valid rises once the pipeline has filled
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      cfg_ready <= 1'b0;
      vld <= '0;
    end else begin
      cfg_ready <= !update;
      vld <= {vld[2:0], 1'b1};
    end
  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic hit;
    logic [ACC_W-1:0] fw_s, fw_n, fw_a, acc;
    logic [PHASE_W-1:0] po_s, po_n, po_a, ph;
    logic [1:0] wv_s, wv_n, wv_a, wv1, wv2;
    logic [OUT_W-1:0] tri_v, alt, sin_q, dout;
    assign hit = take && cfg_ch == CW'(c);
    assign fw_n = hit && cfg_addr == ADDR_FREQ ? cfg_data : fw_s;
    assign po_n = hit && cfg_addr == ADDR_PHASE ? cfg_data[PHASE_W-1:0] : po_s;
    assign wv_n = hit && cfg_addr == ADDR_WAVE ? cfg_data[1:0] : wv_s;
    assign tri_v = ph[PHASE_W-2 -: OUT_W];
    // the commit copies the shadow's next value so a same-edge write is included
    always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
        fw_s <= '0;
        po_s <= '0;
        wv_s <= '0;
        fw_a <= '0;
        po_a <= '0;
        wv_a <= '0;
      end else begin
        fw_s <= fw_n;
        po_s <= po_n;
        wv_s <= wv_n;
        if (update) begin
          fw_a <= fw_n;
          po_a <= po_n;
          wv_a <= wv_n;
        end
      end
    // accumulator, phase offset add, non-sine shaping and output select, wave code travelling with the phase
    always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
        acc <= '0;
        ph <= '0;
        wv1 <= '0;
        wv2 <= '0;
        alt <= '0;
        dout <= '0;
      end else begin
        acc <= phase_clr ? '0 : acc + fw_a;
        ph <= acc[ACC_W-1 -: PHASE_W] + po_a;
        wv1 <= wv_a;
        wv2 <= wv1;
        alt <= wv1 == WAVE_SQU ? {OUT_W{~ph[PHASE_W-1]}} :
               wv1 == WAVE_SAW ? ph[PHASE_W-1 -: OUT_W] :
               ph[PHASE_W-1] ? ~tri_v : tri_v;
        dout <= wv2 == WAVE_SIN ? sin_q : alt;
      end
    dds_sin_lut #(.PHASE_W(PHASE_W), .OUT_W(OUT_W)) u_lut (
      .sys_clk(sys_clk),
      .sys_rst_n(sys_rst_n),
      .phase(ph),
      .sample(sin_q)
    );
    assign data_out[c*OUT_W +: OUT_W] = dout;
  end
endmodule

// File: tb/tb_dds_multi.sv
// tb_dds_multi: directed and randomized checks of dds_multi against a behavioural DDS model
module tb_dds_multi;
  import dds_pkg::*;
  localparam int CH = 2;
  localparam real PI = 3.141592653589793;
  logic sys_clk = 0, sys_rst_n = 0, cfg_valid = 0, update = 0, phase_clr = 0;
  logic cfg_ready, data_valid;
  logic [0:0] cfg_ch = 0;
  logic [1:0] cfg_addr = 0;
  logic [31:0] cfg_data = 0;
  logic [15:0] data_out;
  int checks = 0, errors = 0;
  logic [31:0] sh_fw [CH], a_fw [CH], m_acc [CH];
  logic [11:0] sh_po [CH], a_po [CH];
  logic [1:0] sh_wv [CH], a_wv [CH];
  logic [31:0] h_acc [4][CH];
  logic [11:0] h_po [4][CH];
  logic [1:0] h_wv [4][CH];
  logic m_ready;
  int edges;

  dds_multi #(.CH(CH), .ACC_W(32), .PHASE_W(12), .OUT_W(8)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .update(update),
    .phase_clr(phase_clr), .data_out(data_out), .data_valid(data_valid)
  );

  always #10 sys_clk = ~sys_clk;

  // sample value straight from the waveform definitions
  function automatic int ref_sample(input logic [1:0] wv, input logic [31:0] acc, input logic [11:0] po);
    int p, t;
    real x;
    p = (int'(acc >> 20) + int'(po)) % 4096;
    t = (p >> 3) % 256;
    x = 127.0 * $sin(2.0 * PI * p / 4096.0);
    case (wv)
      2'd0: return 128 + (x >= 0.0 ? $rtoi(x + 0.5) : -$rtoi(0.5 - x));
      2'd1: return p < 2048 ? 255 : 0;
      2'd2: return p >= 2048 ? 255 - t : t;
      default: return p >> 4;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      sh_fw[c] = 0; a_fw[c] = 0; m_acc[c] = 0;
      sh_po[c] = 0; a_po[c] = 0; sh_wv[c] = 0; a_wv[c] = 0;
      for (int k = 0; k < 4; k++) begin
        h_acc[k][c] = 0; h_po[k][c] = 0; h_wv[k][c] = 0;
      end
    end
    m_ready = 0;
    edges = 0;
  endtask

  // one clock edge of the model: writes land in shadows, update commits, samples emerge 3 edges later
  task automatic model_edge();
    logic took;
    took = cfg_valid && m_ready;
    for (int c = 0; c < CH; c++) begin
      if (took && int'(cfg_ch) == c) begin
        if (cfg_addr == ADDR_FREQ) sh_fw[c] = cfg_data;
        if (cfg_addr == ADDR_PHASE) sh_po[c] = cfg_data[11:0];
        if (cfg_addr == ADDR_WAVE) sh_wv[c] = cfg_data[1:0];
      end
      m_acc[c] = phase_clr ? 32'd0 : m_acc[c] + a_fw[c];
      if (update) begin
        a_fw[c] = sh_fw[c]; a_po[c] = sh_po[c]; a_wv[c] = sh_wv[c];
      end
      for (int k = 3; k > 0; k--) begin
        h_acc[k][c] = h_acc[k-1][c]; h_po[k][c] = h_po[k-1][c]; h_wv[k][c] = h_wv[k-1][c];
      end
      h_acc[0][c] = m_acc[c]; h_po[0][c] = a_po[c]; h_wv[0][c] = a_wv[c];
    end
    m_ready = !update;
    edges++;
  endtask

  task automatic step();
    @(posedge sys_clk);
    model_edge();
    #1;
    chk("data_valid", data_valid, edges >= 4);
    chk("cfg_ready", cfg_ready, m_ready);
    if (edges >= 4)
      for (int c = 0; c < CH; c++)
        chk(c == 0 ? "ch0" : "ch1", data_out[c*8 +: 8], ref_sample(h_wv[3][c], h_acc[3][c], h_po[3][c]));
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input int ch, input int a, input logic [31:0] d, output int n);
    logic took;
    cfg_valid = 1; cfg_ch = 1'(ch); cfg_addr = 2'(a); cfg_data = d; n = 0;
    do begin
      took = cfg_ready;
      step();
      n++;
    end while (!took && n < 8);
    cfg_valid = 0;
    chk("wr_accept", took, 1);
  endtask

  task automatic commit(input logic clr);
    update = 1; phase_clr = clr;
    step();
    update = 0; phase_clr = 0;
  endtask

  initial begin
    int n, wraps, hi, prev;
    logic [7:0] s0 [128], s1 [128], trv [4096];
    model_reset();
    #1;
    chk("rst_out", data_out, 0);
    chk("rst_valid", data_valid, 0);
    chk("rst_ready", cfg_ready, 0);
    #34 sys_rst_n = 1;
    run(4);
    chk("boot_ch0", data_out[7:0], 128);

    wr(0, ADDR_FREQ, 32'h0010_0000, n);
    wr(0, ADDR_WAVE, WAVE_SAW, n);
    commit(1);
    run(3);
    chk("saw_start", data_out[7:0], 0);
    wraps = 0;
    prev = data_out[7:0];
    for (int i = 0; i < 4096; i++) begin
      step();
      if (prev == 255 && data_out[7:0] == 0) wraps++;
      prev = data_out[7:0];
    end
    chk("saw_wrap", wraps, 1);

    wr(0, ADDR_FREQ, 32'h0100_0000, n);
    wr(1, ADDR_FREQ, 32'h0100_0000, n);
    wr(1, ADDR_PHASE, 1024, n);
    wr(0, ADDR_WAVE, WAVE_SIN, n);
    wr(1, ADDR_WAVE, WAVE_SIN, n);
    commit(1);
    run(3);
    for (int i = 0; i < 128; i++) begin
      s0[i] = data_out[7:0];
      s1[i] = data_out[15:8];
      step();
    end
    for (int i = 0; i < 64; i += 4) chk("coherence", s1[i], s0[i+64]);

    commit(0);
    chk("hs_ready_low", cfg_ready, 0);
    wr(0, ADDR_WAVE, WAVE_TRI, n);
    chk("hs_wait", n, 2);
    step();
    cfg_valid = 1; cfg_ch = 1; cfg_addr = ADDR_WAVE; cfg_data = WAVE_SAW; update = 1;
    step();
    cfg_valid = 0; update = 0;
    run(4);

    wr(0, ADDR_WAVE, WAVE_SAW, n);
    wr(1, ADDR_WAVE, WAVE_SQU, n);
    commit(1);
    run(3);
    chk("clr_saw", data_out[7:0], 0);
    chk("clr_squ", data_out[15:8], 255);

    wr(0, ADDR_FREQ, 32'h0010_0000, n);
    wr(0, ADDR_WAVE, WAVE_SQU, n);
    commit(1);
    run(2);
    hi = 0;
    for (int i = 0; i < 4096; i++) begin
      step();
      if (data_out[7:0] == 255) hi++;
    end
    chk("squ_high", hi, 2048);
    wr(0, ADDR_WAVE, WAVE_TRI, n);
    commit(1);
    run(2);
    for (int i = 0; i < 4096; i++) begin
      step();
      trv[i] = data_out[7:0];
    end
    chk("tri_peak", trv[2047], 255);
    chk("tri_end", trv[4095], 0);

    for (int r = 0; r < 30; r++) begin
      wr($urandom_range(0, 1), $urandom_range(0, 3), $urandom, n);
      if ($urandom_range(0, 2) == 0) commit(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 4) == 0) begin
        phase_clr = 1;
        step();
        phase_clr = 0;
      end
      run($urandom_range(1, 12));
    end

    #4 sys_rst_n = 0;
    #1;
    chk("mid_rst_out", data_out, 0);
    chk("mid_rst_valid", data_valid, 0);
    chk("mid_rst_ready", cfg_ready, 0);
    model_reset();
    #2 sys_rst_n = 1;
    run(4);
    chk("mid_rst_ch0", data_out[7:0], 128);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
